core_seq_ctrl: RTL and testbench
================================

Name: core_seq_ctrl

Overview:
- Parametrised multi-cycle sequencer for the RISC-V core. It replaces the fixed-timing control unit.
- Drives the fetch, decode, memory and writeback strobes for the PC, instruction memory, register file and data memory.
- Inserts configurable wait states for slower instruction/data memories, drains FENCE for a set number of cycles, and latches HALT.
- Exposes cycle and retired-instruction counters for the LED/debug path.

Parameters:
IMEM_WAIT, 1, extra wait cycles after the imem read strobe before the instruction is valid (0..15)
DMEM_WAIT, 1, extra wait cycles after the dmem strobe before load data is valid or the store is complete (0..15)
FENCE_CYCLES, 2, cycles spent in FENCE drain (1..15)
CNT_W, 32, width of cycle_cnt and instret_cnt

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
halt_req  in  1  decoder HALT OR PC halt flag
ld  in  1  decoded load
st  in  1  decoded store
br  in  1  decoded branch
fence  in  1  decoded FENCE
wen_dmem_dec  in  4  byte enables from decoder for the store
step  in  1  single-step advance pulse (used only with the optional feature)
imem_rden  out  1  instruction memory read strobe
pc_wen  out  1  PC update enable
regf_wen  out  1  register file write enable
dmem_rden  out  1  data memory read strobe
dmem_wen  out  4  data memory byte write enables
halted  out  1  core stopped
cycle_cnt  out  CNT_W  cycles since reset, excluding HALT
instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset: async and active-high. All outputs and counters go to 0 immediately and the state goes to IDLE.
- Outputs: Moore-style, decoded from the registered state only. The only exception is dmem_wen, which is a register captured in DECODE.
- State transitions and per-state outputs:
  - IDLE: all strobes 0. Moves to FETCH on the next clk.
  - FETCH: imem_rden=1 for exactly 1 cycle. Moves to FETCH_WAIT if IMEM_WAIT>0, otherwise to DECODE.
  - FETCH_WAIT: stays for exactly IMEM_WAIT cycles, using a 4-bit down-counter loaded in FETCH. Then moves to DECODE. imem_rden=0 here.
  - DECODE: 1 cycle, no strobes. Decode inputs are sampled at the end of this cycle. Next state by priority:
    - halt_req -> HALT
    - fence -> FENCE
    - ld -> MEM
    - st -> MEM
    - otherwise -> WB
  - DECODE also captures the store type (st && !ld) and wen_dmem_dec into the dmem_wen register, and captures the writeback class.
  - ld and st both asserted is treated as a load; dmem_wen stays 0.
  - MEM: 1 cycle. dmem_rden=1 for a load. For a store, dmem_wen = captured enables, asserted this cycle only. Then moves to MEM_WAIT if DMEM_WAIT>0, otherwise to WB.
  - MEM_WAIT: stays DMEM_WAIT cycles. dmem_rden=0 and dmem_wen=0. Then moves to WB.
  - FENCE: stays FENCE_CYCLES cycles, no strobes. Then moves to WB.
  - WB: 1 cycle.
    - pc_wen=1.
    - regf_wen=1 unless the instruction was a store, branch or fence.
    - instret_cnt increments by 1.
    - Next state is FETCH.
  - HALT: halted=1 and all strobes 0. Sticky until rst. The halting instruction does not retire: no pc_wen and no instret increment.
- Latency per instruction, from FETCH entry to the next FETCH entry:
  - ALU, branch or jump: 3+IMEM_WAIT
  - load or store: 4+IMEM_WAIT+DMEM_WAIT
  - fence: 3+IMEM_WAIT+FENCE_CYCLES
- Counters: both wrap modulo 2^CNT_W without saturating.
  - cycle_cnt increments every clk in any state except HALT.
  - In the HALT entry cycle cycle_cnt still increments, and then it freezes.
- Exclusivity: pc_wen, regf_wen, imem_rden, dmem_rden and dmem_wen are never asserted in the same cycle as each other, except pc_wen with regf_wen in WB.
- Inputs: only sampled in DECODE. Changes in other states are ignored.
- Reset mid-operation: async reset clears any in-flight store strobe in the same cycle. No partial write may be issued after rst rises.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - WB moves to PAUSE instead of FETCH.
  - PAUSE drives no strobes; cycle_cnt still counts.
  - PAUSE moves to FETCH on the clk where step=1. step=1 held for multiple cycles advances only one instruction, because the sequencer re-enters PAUSE after the next WB.
  - step is ignored in every state other than PAUSE.
- Undefined: the step port exists but is ignored, and the PAUSE state is not built.

Test Plan:
- ALU instruction stream, IMEM_WAIT=2: release rst, decode inputs all 0 -> imem_rden pulses every 5 cycles; pc_wen and regf_wen both high in the 5th cycle; instret_cnt=4 after 20 cycles past IDLE.
- Load, IMEM_WAIT=2, DMEM_WAIT=1: ld=1 in DECODE -> dmem_rden high exactly 1 cycle, 1 cycle after DECODE; WB 2 cycles after MEM; 7 cycles per load; regf_wen=1.
- Store: st=1, wen_dmem_dec=4'b0011 -> dmem_wen=4'b0011 for exactly 1 cycle; regf_wen=0 in WB; pc_wen=1.
- Priority: halt_req=1, ld=1, fence=1 together in DECODE -> HALT; halted=1; no further strobes for 100 cycles; cycle_cnt frozen; instret_cnt unchanged.
- Fence, FENCE_CYCLES=3 and branch br=1: fence instruction takes 8 cycles with IMEM_WAIT=2 and regf_wen=0; branch takes 5 cycles with regf_wen=0.
- Reset and wrap: rst pulsed while in MEM of a store -> dmem_wen drops the same cycle and the FSM restarts in IDLE. With CNT_W=4, 16 retirements -> instret_cnt wraps to 0. With SINGLE_STEP_EN, the FSM stays in PAUSE until step=1, then retires exactly one instruction.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle sequencer for the RISC-V core.
//
// Each instruction walks FETCH -> [FETCH_WAIT] -> DECODE -> {MEM [MEM_WAIT] | FENCE | -} -> WB,
// or stops in HALT (sticky until rst). The strobes are decoded from the registered state
// only. dmem_wen is a register that is loaded in DECODE and is visible during MEM alone.
//
// Parameters:
//   IMEM_WAIT    extra cycles after the imem read strobe (0..15)
//   DMEM_WAIT    extra cycles after the dmem strobe (0..15)
//   FENCE_CYCLES cycles spent draining a FENCE (1..15)
//   CNT_W        width of cycle_cnt / instret_cnt (both wrap)
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   halt_req, ld, st, br, fence, wen_dmem_dec
//                     decoder inputs, sampled in DECODE only
//   step              single-step advance pulse (optional feature)
//   imem_rden, pc_wen, regf_wen, dmem_rden, dmem_wen
//                     memory / PC / register-file strobes
//   halted            core stopped
//   cycle_cnt         cycles since reset, frozen while halted
//   instret_cnt       retired instructions
//
// Optional feature (macro SINGLE_STEP_EN): WB parks in PAUSE, and a step pulse releases
// exactly one further instruction. Without the macro, step is ignored and PAUSE is not built.

module core_seq_ctrl #(
  parameter int unsigned IMEM_WAIT    = 1,
  parameter int unsigned DMEM_WAIT    = 1,
  parameter int unsigned FENCE_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic             ld,
  input  logic             st,
  input  logic             br,
  input  logic             fence,
  input  logic [3:0]       wen_dmem_dec,
  input  logic             step,
  output logic             imem_rden,
  output logic             pc_wen,
  output logic             regf_wen,
  output logic             dmem_rden,
  output logic [3:0]       dmem_wen,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StFetchWait,
    StDecode,
    StMem,
    StMemWait,
    StFence,
    StWb,
    StHalt
`ifdef SINGLE_STEP_EN
    , StPause
`endif
  } state_e;

  // Wait counters count down to zero, so they are loaded with (cycles - 1).
  localparam logic [3:0] ImemLoad  = 4'((IMEM_WAIT > 0) ? IMEM_WAIT - 1 : 0);
  localparam logic [3:0] DmemLoad  = 4'((DMEM_WAIT > 0) ? DMEM_WAIT - 1 : 0);
  localparam logic [3:0] FenceLoad = 4'((FENCE_CYCLES > 0) ? FENCE_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [3:0]       dmem_wen_q, dmem_wen_d;
  logic             is_load_q, is_load_d;
  logic             regf_cls_q, regf_cls_d;
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

  // ld together with st counts as a load.
  logic is_store;
  assign is_store = st && !ld;

`ifndef SINGLE_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    dmem_wen_d = '0;
    is_load_d  = is_load_q;
    regf_cls_d = regf_cls_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (IMEM_WAIT > 0) begin
          state_d = StFetchWait;
          wait_d  = ImemLoad;
        end else begin
          state_d = StDecode;
        end
      end
      StFetchWait: begin
        if (wait_q == 4'd0) state_d = StDecode;
        else                wait_d  = wait_q - 4'd1;
      end
      StDecode: begin
        is_load_d  = ld;
        regf_cls_d = !(is_store || br || fence);
        if (halt_req) begin
          state_d = StHalt;
        end else if (fence) begin
          state_d = StFence;
          wait_d  = FenceLoad;
        end else if (ld || st) begin
          state_d = StMem;
          // Load the enables only for a real store so they appear in MEM and nowhere else.
          if (is_store) dmem_wen_d = wen_dmem_dec;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (DMEM_WAIT > 0) begin
          state_d = StMemWait;
          wait_d  = DmemLoad;
        end else begin
          state_d = StWb;
        end
      end
      StMemWait: begin
        if (wait_q == 4'd0) state_d = StWb;
        else                wait_d  = wait_q - 4'd1;
      end
      StFence: begin
        if (wait_q == 4'd0) state_d = StWb;
        else                wait_d  = wait_q - 4'd1;
      end
`ifdef SINGLE_STEP_EN
      StWb:    state_d = StPause;
      StPause: if (step) state_d = StFetch;
`else
      StWb:    state_d = StFetch;
`endif
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      wait_q        <= '0;
      dmem_wen_q    <= '0;
      is_load_q     <= 1'b0;
      regf_cls_q    <= 1'b0;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      dmem_wen_q <= dmem_wen_d;
      is_load_q  <= is_load_d;
      regf_cls_q <= regf_cls_d;
      // The cycle that enters HALT is still counted; the counter freezes afterwards.
      if (state_q != StHalt) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (state_q == StWb)   instret_cnt_q <= instret_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    imem_rden = 1'b0;
    pc_wen    = 1'b0;
    regf_wen  = 1'b0;
    dmem_rden = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      StFetch: imem_rden = 1'b1;
      StMem:   dmem_rden = is_load_q;
      StWb: begin
        pc_wen   = 1'b1;
        regf_wen = regf_cls_q;
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  assign dmem_wen    = dmem_wen_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl. Every instruction is expanded into the cycle-by-cycle
// strobe pattern implied by its class and the wait parameters. Counters are tracked
// arithmetically. A second instance with CNT_W=4 checks wrap-around.
module tb_core_seq_ctrl;
  localparam int unsigned IW = 2;
  localparam int unsigned DW = 1;
  localparam int unsigned FC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halt_req = 1'b0, ld = 1'b0, st = 1'b0, br = 1'b0, fence = 1'b0, step = 1'b0;
  logic [3:0] wen = 4'd0;

  logic        imem_rden, pc_wen, regf_wen, dmem_rden, halted;
  logic [3:0]  dmem_wen;
  logic [31:0] cycle_cnt, instret_cnt;
  logic        w_imem_rden, w_pc_wen, w_regf_wen, w_dmem_rden, w_halted;
  logic [3:0]  w_dmem_wen;
  logic [3:0]  w_cycle_cnt, w_instret_cnt;

  core_seq_ctrl #(.IMEM_WAIT(IW), .DMEM_WAIT(DW), .FENCE_CYCLES(FC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req), .ld(ld), .st(st), .br(br), .fence(fence),
    .wen_dmem_dec(wen), .step(step), .imem_rden(imem_rden), .pc_wen(pc_wen),
    .regf_wen(regf_wen), .dmem_rden(dmem_rden), .dmem_wen(dmem_wen), .halted(halted),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  core_seq_ctrl #(.IMEM_WAIT(IW), .DMEM_WAIT(DW), .FENCE_CYCLES(FC), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .halt_req(halt_req), .ld(ld), .st(st), .br(br), .fence(fence),
    .wen_dmem_dec(wen), .step(step), .imem_rden(w_imem_rden), .pc_wen(w_pc_wen),
    .regf_wen(w_regf_wen), .dmem_rden(w_dmem_rden), .dmem_wen(w_dmem_wen),
    .halted(w_halted), .cycle_cnt(w_cycle_cnt), .instret_cnt(w_instret_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_cyc = 32'd0;
  logic [31:0] exp_ret = 32'd0;

  localparam int ClsAlu = 0, ClsLoad = 1, ClsStore = 2, ClsBranch = 3, ClsFence = 4,
                 ClsHalt = 5;

  // {imem_rden, pc_wen, regf_wen, dmem_rden, dmem_wen[3:0], halted}
  function automatic logic [8:0] mk(input logic im, input logic pc, input logic rf,
                                    input logic rd, input logic [3:0] wn, input logic h);
    return {im, pc, rf, rd, wn, h};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode inputs are only meaningful in DECODE; drive noise everywhere else.
  task automatic garbage();
    halt_req = 1'($urandom_range(0, 1));
    ld       = 1'($urandom_range(0, 1));
    st       = 1'($urandom_range(0, 1));
    br       = 1'($urandom_range(0, 1));
    fence    = 1'($urandom_range(0, 1));
    wen      = 4'($urandom);
    step     = 1'($urandom_range(0, 1));
  endtask

  // Check one cycle at the falling edge, then advance the counter model across the next rise.
  task automatic tick(input logic [8:0] exp_out, input bit in_halt, input string tag);
    @(negedge clk);
    chk({tag, ".out"}, 32'({imem_rden, pc_wen, regf_wen, dmem_rden, dmem_wen, halted}),
        32'(exp_out));
    chk({tag, ".out_w"}, 32'({w_imem_rden, w_pc_wen, w_regf_wen, w_dmem_rden, w_dmem_wen,
        w_halted}), 32'(exp_out));
    chk({tag, ".cycle_cnt"}, cycle_cnt, exp_cyc);
    chk({tag, ".instret_cnt"}, instret_cnt, exp_ret);
    chk({tag, ".cycle_cnt_w"}, 32'(w_cycle_cnt), 32'(exp_cyc[3:0]));
    chk({tag, ".instret_cnt_w"}, 32'(w_instret_cnt), 32'(exp_ret[3:0]));
    @(posedge clk);
    if (!in_halt) exp_cyc++;
    if (exp_out[7]) exp_ret++;
    #1;
  endtask

  task automatic fetch_to_decode(input int cls, input logic [3:0] swen);
    garbage();
    tick(mk(1, 0, 0, 0, 4'd0, 0), 0, "fetch");
    for (int i = 0; i < int'(IW); i++) begin
      garbage();
      tick(9'd0, 0, "fetch_wait");
    end
    halt_req = 1'b0; ld = 1'b0; st = 1'b0; br = 1'b0; fence = 1'b0;
    wen = 4'($urandom);
    case (cls)
      ClsLoad:   begin ld = 1'b1; st = 1'($urandom_range(0, 1)); end
      ClsStore:  begin st = 1'b1; wen = swen; end
      ClsBranch: br = 1'b1;
      ClsFence:  begin fence = 1'b1; ld = 1'($urandom_range(0, 1)); end
      ClsHalt: begin
        halt_req = 1'b1; ld = 1'b1; fence = 1'b1;
        st = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
      end
      default: ;
    endcase
    tick(9'd0, 0, "decode");
    garbage();
  endtask

  task automatic run_instr(input int cls, input logic [3:0] swen);
    fetch_to_decode(cls, swen);
    case (cls)
      ClsAlu: tick(mk(0, 1, 1, 0, 4'd0, 0), 0, "alu_wb");
      ClsLoad: begin
        tick(mk(0, 0, 0, 1, 4'd0, 0), 0, "ld_mem");
        for (int i = 0; i < int'(DW); i++) begin garbage(); tick(9'd0, 0, "ld_wait"); end
        garbage();
        tick(mk(0, 1, 1, 0, 4'd0, 0), 0, "ld_wb");
      end
      ClsStore: begin
        tick(mk(0, 0, 0, 0, swen, 0), 0, "st_mem");
        for (int i = 0; i < int'(DW); i++) begin garbage(); tick(9'd0, 0, "st_wait"); end
        garbage();
        tick(mk(0, 1, 0, 0, 4'd0, 0), 0, "st_wb");
      end
      ClsBranch: tick(mk(0, 1, 0, 0, 4'd0, 0), 0, "br_wb");
      ClsFence: begin
        for (int i = 0; i < int'(FC); i++) begin garbage(); tick(9'd0, 0, "fence_drain"); end
        garbage();
        tick(mk(0, 1, 0, 0, 4'd0, 0), 0, "fence_wb");
      end
      default: ;
    endcase
`ifdef SINGLE_STEP_EN
    if (cls != ClsHalt) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        garbage();
        step = (i == n - 1);
        tick(9'd0, 0, "pause");
      end
    end
`endif
  endtask

  initial begin
    logic [3:0] swen;
    garbage();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.out", 32'({imem_rden, pc_wen, regf_wen, dmem_rden, dmem_wen, halted}), 32'd0);
    chk("reset.cycle_cnt", cycle_cnt, 32'd0);
    chk("reset.instret_cnt", instret_cnt, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_cyc = 32'd0;
    exp_ret = 32'd0;
    tick(9'd0, 0, "idle");

    for (int i = 0; i < 4; i++) run_instr(ClsAlu, 4'd0);
    chk("alu_stream.instret", instret_cnt, 32'd4);

    run_instr(ClsLoad, 4'd0);
    run_instr(ClsStore, 4'b0011);
    run_instr(ClsFence, 4'd0);
    run_instr(ClsBranch, 4'd0);

    for (int i = 0; i < 40; i++) begin
      swen = 4'($urandom);
      run_instr(int'($urandom_range(0, 4)), swen);
    end

    // Reset in the middle of a store's MEM cycle.
    fetch_to_decode(ClsStore, 4'b0011);
    @(negedge clk);
    chk("rst_mid_store.wen_before", 32'(dmem_wen), 32'h3);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_store.out", 32'({imem_rden, pc_wen, regf_wen, dmem_rden, dmem_wen, halted}),
        32'd0);
    chk("rst_mid_store.out_w", 32'(w_dmem_wen), 32'd0);
    chk("rst_mid_store.cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_mid_store.instret_cnt", instret_cnt, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_cyc = 32'd0;
    exp_ret = 32'd0;
    tick(9'd0, 0, "idle_after_rst");

    for (int i = 0; i < 16; i++) begin
      swen = 4'($urandom);
      run_instr(int'($urandom_range(0, 4)), swen);
    end
    chk("wrap.instret_w", 32'(w_instret_cnt), 32'd0);
    chk("wrap.instret", instret_cnt, 32'd16);

    // halt_req wins over fence and ld; the core then stays silent with frozen counters.
    run_instr(ClsHalt, 4'd0);
    for (int i = 0; i < 100; i++) begin
      garbage();
      tick(mk(0, 0, 0, 0, 4'd0, 1), 1, "halt");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
